// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction fields from ID, forwarding producers,
// and the registered EX-side outputs. The stage itself uses the slave modport.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [WIDTH-1:0] id_imm;
    logic [REGW-1:0]  id_rs;
    logic [REGW-1:0]  id_rt;
    logic [REGW-1:0]  id_rd;
    logic [1:0]       id_alu_op;
    logic [5:0]       id_funct;
    logic             id_alu_src;
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             id_branch;

    logic             exm_reg_write;
    logic [REGW-1:0]  exm_rd;
    logic [WIDTH-1:0] exm_result;
    logic             mw_reg_write;
    logic [REGW-1:0]  mw_rd;
    logic [WIDTH-1:0] mw_result;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_operation;
    logic [WIDTH-1:0] ex_write_data;
    logic [REGW-1:0]  ex_dest;
    logic             ex_valid;
    logic             ex_illegal;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_branch;
    logic             load_use_hazard;

    modport slave (
        input  stall, flush, in_valid,
        input  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
        input  id_alu_op, id_funct,
        input  id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
        input  id_mem_write, id_mem_to_reg, id_branch,
        input  exm_reg_write, exm_rd, exm_result,
        input  mw_reg_write, mw_rd, mw_result,
        output alu_a, alu_b, alu_operation, ex_write_data, ex_dest,
        output ex_valid, ex_illegal, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_mem_to_reg, ex_branch, load_use_hazard
    );

    modport master (
        output stall, flush, in_valid,
        output id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
        output id_alu_op, id_funct,
        output id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
        output id_mem_write, id_mem_to_reg, id_branch,
        output exm_reg_write, exm_rd, exm_result,
        output mw_reg_write, mw_rd, mw_result,
        input  alu_a, alu_b, alu_operation, ex_write_data, ex_dest,
        input  ex_valid, ex_illegal, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_mem_to_reg, ex_branch, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-op decode, EX/MEM and MEM/WB operand
// forwarding, stall-time operand refresh and load-use hazard detection.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    typedef enum logic [2:0] {
        alu_and = 3'b000,
        alu_or  = 3'b001,
        alu_add = 3'b010,
        alu_sub = 3'b110,
        alu_slt = 3'b111
    } alu_code_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    logic             valid_q;
    logic             illegal_q;
    ctrl_t            ctrl_q;
    alu_code_e        op_q;
    logic             alu_src_q;
    logic [REGW-1:0]  dest_q;
    logic [REGW-1:0]  rs_idx;
    logic [REGW-1:0]  rt_idx;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] imm;

    alu_code_e        dec_op;
    logic             dec_illegal;
    ctrl_t            id_ctrl;
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // EX/MEM is the younger producer, so it shadows MEM/WB; $0 is hardwired.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [REGW-1:0]  idx,
        input logic [WIDTH-1:0] val,
        input logic             exm_we,
        input logic [REGW-1:0]  exm_rd,
        input logic [WIDTH-1:0] exm_res,
        input logic             mw_we,
        input logic [REGW-1:0]  mw_rd,
        input logic [WIDTH-1:0] mw_res
    );
        logic [WIDTH-1:0] r;
        r = val;
        if (idx != '0) begin
            if (exm_we && exm_rd == idx)     r = exm_res;
            else if (mw_we && mw_rd == idx)  r = mw_res;
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dec_op      = alu_add;
        dec_illegal = 1'b0;
        unique case (bus.id_alu_op)
            2'b00: dec_op = alu_add;
            2'b01: dec_op = alu_sub;
            2'b11: dec_op = alu_or;
            2'b10: begin
                case (bus.id_funct)
                    6'b100000: dec_op = alu_add;
                    6'b100010: dec_op = alu_sub;
                    6'b100100: dec_op = alu_and;
                    6'b100101: dec_op = alu_or;
                    6'b101010: dec_op = alu_slt;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_op = alu_add;
        endcase
    end

    assign id_ctrl = '{reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       branch:     bus.id_branch};

    assign fwd_rs = fwd(rs_idx, rs_val, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                        bus.mw_reg_write, bus.mw_rd, bus.mw_result);
    assign fwd_rt = fwd(rt_idx, rt_val, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                        bus.mw_reg_write, bus.mw_rd, bus.mw_result);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: data fields are reset too, so a flushed or reset slot never forwards stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            op_q      <= alu_and;
            alu_src_q <= 1'b0;
            dest_q    <= '0;
            rs_idx    <= '0;
            rt_idx    <= '0;
            rs_val    <= '0;
            rt_val    <= '0;
            imm       <= '0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            op_q      <= alu_and;
            alu_src_q <= 1'b0;
            dest_q    <= '0;
            rs_idx    <= '0;
            rt_idx    <= '0;
            rs_val    <= '0;
            rt_val    <= '0;
            imm       <= '0;
        end else if (bus.stall) begin
            // Fold in producers that retire while we wait, they will be gone next cycle.
            rs_val <= fwd_rs;
            rt_val <= fwd_rt;
        end else begin
            valid_q   <= bus.in_valid;
            illegal_q <= bus.in_valid & dec_illegal;
            ctrl_q    <= bus.in_valid ? id_ctrl : '0;
            op_q      <= dec_op;
            alu_src_q <= bus.id_alu_src;
            dest_q    <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            rs_idx    <= bus.id_rs;
            rt_idx    <= bus.id_rt;
            rs_val    <= bus.id_rs_data;
            rt_val    <= bus.id_rt_data;
            imm       <= bus.id_imm;
        end
    end

    assign bus.alu_a         = fwd_rs;
    assign bus.alu_b         = alu_src_q ? imm : fwd_rt;
    assign bus.ex_write_data = fwd_rt;
    assign bus.alu_operation = op_q;
    assign bus.ex_dest       = dest_q;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_illegal    = illegal_q;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_branch     = ctrl_q.branch;

    assign bus.load_use_hazard = valid_q & ctrl_q.mem_read & (dest_q != '0) &
                                 ((dest_q == bus.id_rs) | (dest_q == bus.id_rt)) &
                                 bus.in_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes model expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;
    localparam int WIDTH = 32;
    localparam int REGW  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();
    id_ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic        rst_n, stall, flush, in_valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch;
        logic        exm_rw;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        mw_rw;
        logic [4:0]  mw_rd;
        logic [31:0] mw_res;
    } stim_t;

    // Architectural view of the instruction sitting in EX.
    typedef struct packed {
        logic        known;
        logic        valid, illegal;
        logic [4:0]  ctrl;
        logic [2:0]  op;
        logic [4:0]  dest, rs_idx, rt_idx;
        logic [31:0] rs_val, rt_val, imm;
        logic        alu_src;
    } model_t;

    typedef struct packed {
        logic        known;
        logic [31:0] alu_a, alu_b, wd;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic        valid, illegal;
        logic [4:0]  ctrl;
        logic        hazard;
    } exp_t;

    localparam logic [5:0] FN_TAB   [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    localparam logic [2:0] CODE_TAB [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    exp_t   expq[$];
    model_t m;
    int     total = 0;
    int     passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void ref_decode(input logic [1:0] alu_op, input logic [5:0] funct,
                                       output logic [2:0] op, output logic illegal);
        op = 3'b010;
        illegal = 1'b0;
        if (alu_op == 2'b01) op = 3'b110;
        else if (alu_op == 2'b11) op = 3'b001;
        else if (alu_op == 2'b10) begin
            illegal = 1'b1;
            for (int i = 0; i < 5; i++)
                if (FN_TAB[i] == funct) begin
                    op = CODE_TAB[i];
                    illegal = 1'b0;
                end
        end
    endfunction

    // Latest writer wins: apply the older MEM/WB value first, then EX/MEM over it.
    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] val,
                                            input stim_t s);
        logic [31:0] r;
        r = val;
        if (idx != 0) begin
            if (s.mw_rw && s.mw_rd == idx) r = s.mw_res;
            if (s.exm_rw && s.exm_rd == idx) r = s.exm_res;
        end
        return r;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t        e;
        logic [2:0]  op;
        logic        ill;
        @(posedge clk);
        #1;
        rst_n              = s.rst_n;
        bus.stall          = s.stall;
        bus.flush          = s.flush;
        bus.in_valid       = s.in_valid;
        bus.id_rs_data     = s.rs_data;
        bus.id_rt_data     = s.rt_data;
        bus.id_imm         = s.imm;
        bus.id_rs          = s.rs;
        bus.id_rt          = s.rt;
        bus.id_rd          = s.rd;
        bus.id_alu_op      = s.alu_op;
        bus.id_funct       = s.funct;
        bus.id_alu_src     = s.alu_src;
        bus.id_reg_dst     = s.reg_dst;
        bus.id_reg_write   = s.reg_write;
        bus.id_mem_read    = s.mem_read;
        bus.id_mem_write   = s.mem_write;
        bus.id_mem_to_reg  = s.mem_to_reg;
        bus.id_branch      = s.branch;
        bus.exm_reg_write  = s.exm_rw;
        bus.exm_rd         = s.exm_rd;
        bus.exm_result     = s.exm_res;
        bus.mw_reg_write   = s.mw_rw;
        bus.mw_rd          = s.mw_rd;
        bus.mw_result      = s.mw_res;

        if (!s.rst_n) begin
            m = '0;
            m.known = 1'b1;
        end

        e.known   = m.known;
        e.alu_a   = ref_fwd(m.rs_idx, m.rs_val, s);
        e.wd      = ref_fwd(m.rt_idx, m.rt_val, s);
        e.alu_b   = m.alu_src ? m.imm : e.wd;
        e.op      = m.op;
        e.dest    = m.dest;
        e.valid   = m.valid;
        e.illegal = m.illegal;
        e.ctrl    = m.ctrl;
        e.hazard  = m.valid && m.ctrl[3] && m.dest != 0 &&
                    (m.dest == s.rs || m.dest == s.rt) && s.in_valid;
        expq.push_back(e);

        if (!s.rst_n) begin
            // state stays cleared while reset is held
        end else if (s.flush) begin
            m = '0;
            m.known = 1'b1;
        end else if (s.stall) begin
            m.rs_val = e.alu_a;
            m.rt_val = e.wd;
        end else begin
            ref_decode(s.alu_op, s.funct, op, ill);
            m.known   = s.in_valid;
            m.valid   = s.in_valid;
            m.op      = op;
            m.illegal = ill & s.in_valid;
            m.ctrl    = s.in_valid ? {s.reg_write, s.mem_read, s.mem_write, s.mem_to_reg, s.branch}
                                   : 5'b0;
            m.dest    = s.reg_dst ? s.rd : s.rt;
            m.rs_idx  = s.rs;
            m.rt_idx  = s.rt;
            m.rs_val  = s.rs_data;
            m.rt_val  = s.rt_data;
            m.imm     = s.imm;
            m.alu_src = s.alu_src;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
                check("ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                   bus.ex_mem_to_reg, bus.ex_branch}), 32'(e.ctrl));
                check("load_use_hazard", 32'(bus.load_use_hazard), 32'(e.hazard));
                if (e.known) begin
                    check("ex_illegal", 32'(bus.ex_illegal), 32'(e.illegal));
                    check("alu_operation", 32'(bus.alu_operation), 32'(e.op));
                    check("ex_dest", 32'(bus.ex_dest), 32'(e.dest));
                    check("alu_a", bus.alu_a, e.alu_a);
                    check("alu_b", bus.alu_b, e.alu_b);
                    check("ex_write_data", bus.ex_write_data, e.wd);
                end
            end
        end
    end

    initial begin : driver
        stim_t s, t;
        logic [5:0] sweep [6];
        sweep = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        m = '0;
        m.known = 1'b1;

        // Reset held while ID offers a valid add
        s = idle_stim();
        s.rst_n = 1'b0; s.in_valid = 1'b1; s.alu_op = 2'b10; s.funct = 6'b100000;
        repeat (3) step(s);

        // Simple add, then decode sweep
        s = idle_stim();
        s.in_valid = 1'b1; s.alu_op = 2'b10; s.funct = 6'b100000;
        s.rs = 5'd1; s.rt = 5'd2; s.rs_data = 32'd5; s.rt_data = 32'd3;
        s.reg_dst = 1'b1; s.rd = 5'd9; s.reg_write = 1'b1;
        step(s);
        for (int i = 0; i < 6; i++) begin
            s.funct = sweep[i];
            step(s);
        end
        s.alu_op = 2'b01; step(s);
        s.alu_op = 2'b11; step(s);
        step(idle_stim());

        // Forwarding priority
        s = idle_stim();
        s.in_valid = 1'b1; s.rs = 5'd4; s.rt = 5'd4; s.rs_data = 32'd1; s.rt_data = 32'd1;
        step(s);
        t = s;
        t.exm_rw = 1'b1; t.exm_rd = 5'd4; t.exm_res = 32'hAAAA;
        t.mw_rw = 1'b1;  t.mw_rd = 5'd4;  t.mw_res = 32'hBBBB;
        step(t);
        t.exm_rw = 1'b0;
        step(t);
        t.exm_rw = 1'b1; t.exm_rd = 5'd0; t.mw_rd = 5'd0;
        step(t);
        step(idle_stim());

        // Load-use: lw into $8 held in EX by stall
        s = idle_stim();
        s.in_valid = 1'b1; s.rs = 5'd2; s.rt = 5'd8; s.mem_read = 1'b1; s.reg_write = 1'b1;
        s.mem_to_reg = 1'b1; s.alu_src = 1'b1; s.imm = 32'd16;
        step(s);
        t = idle_stim();
        t.in_valid = 1'b1; t.stall = 1'b1; t.rs = 5'd3; t.rt = 5'd8;
        step(t);
        t.rs = 5'd0; t.rt = 5'd0;
        step(t);
        step(idle_stim());

        // Stall refresh: MEM/WB value visible only in the first stall cycle
        s = idle_stim();
        s.in_valid = 1'b1; s.alu_op = 2'b10; s.funct = 6'b100000;
        s.rs = 5'd6; s.rt = 5'd7; s.rs_data = 32'h11; s.rt_data = 32'h22;
        step(s);
        t = idle_stim();
        t.stall = 1'b1; t.mw_rw = 1'b1; t.mw_rd = 5'd6; t.mw_res = 32'h1234;
        step(t);
        t.mw_rw = 1'b0;
        step(t);
        step(idle_stim());

        // Flush during stall
        s = idle_stim();
        s.in_valid = 1'b1; s.reg_write = 1'b1; s.mem_write = 1'b1; s.rs = 5'd1; s.rt = 5'd2;
        step(s);
        t = idle_stim();
        t.stall = 1'b1; t.flush = 1'b1;
        step(t);
        step(idle_stim());

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            s = idle_stim();
            s.rst_n      = !($urandom_range(0, 99) < 2);
            s.stall      = ($urandom_range(0, 99) < 20);
            s.flush      = ($urandom_range(0, 99) < 8);
            s.in_valid   = ($urandom_range(0, 99) < 80);
            s.rs_data    = $urandom;
            s.rt_data    = $urandom;
            s.imm        = $urandom;
            s.rs         = 5'($urandom_range(0, 7));
            s.rt         = 5'($urandom_range(0, 7));
            s.rd         = 5'($urandom_range(0, 7));
            s.alu_op     = 2'($urandom_range(0, 3));
            s.funct      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : sweep[$urandom_range(0, 4)];
            s.alu_src    = 1'($urandom);
            s.reg_dst    = 1'($urandom);
            s.reg_write  = 1'($urandom);
            s.mem_read   = 1'($urandom);
            s.mem_write  = 1'($urandom);
            s.mem_to_reg = 1'($urandom);
            s.branch     = 1'($urandom);
            s.exm_rw     = 1'($urandom);
            s.exm_rd     = 5'($urandom_range(0, 7));
            s.exm_res    = $urandom;
            s.mw_rw      = 1'($urandom);
            s.mw_rd      = 5'($urandom_range(0, 7));
            s.mw_res     = $urandom;
            step(s);
        end

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
